// File: rtl/amo_pkg.sv
// Shared definitions for the AMO executor: funct5 codes, FSM states and
// the per-core LR/SC reservation entry.
`ifndef CORE_NUMS
`define CORE_NUMS 2
`endif

package amo_pkg;

  localparam int AMO_XLEN = 32;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } amo_state_e;

  typedef struct packed {
    logic                  valid;
    logic [AMO_XLEN-1:2]   addr;
  } resv_entry_t;

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write operator for AMO instructions.
// Codes without a dedicated operation (including LR/SC) fall back to ADD.
module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = AMO_XLEN
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      funct5,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val + operand;
    case (funct5)
      AMO_SWAP: new_val = operand;
      AMO_XOR:  new_val = old_val ^ operand;
      AMO_OR:   new_val = old_val | operand;
      AMO_AND:  new_val = old_val & operand;
      AMO_MIN:  new_val = ($signed(old_val) < $signed(operand)) ? old_val : operand;
      AMO_MAX:  new_val = ($signed(old_val) > $signed(operand)) ? old_val : operand;
      AMO_MINU: new_val = (old_val < operand) ? old_val : operand;
      AMO_MAXU: new_val = (old_val > operand) ? old_val : operand;
      default:  new_val = old_val + operand;
    endcase
  end

endmodule

// File: rtl/amo_executor.sv
// Executes one arbitrated AMO / LR / SC / load / store at a time against the
// shared memory port. Define AMO_LRSC_EN to build per-core LR/SC reservations.
module amo_executor
  import amo_pkg::*;
#(
  parameter int XLEN           = AMO_XLEN,
  parameter int CORE_NUMS      = `CORE_NUMS,
  parameter int CORE_NUMS_BITS = (CORE_NUMS == 1) ? 1 : $clog2(CORE_NUMS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CORE_NUMS_BITS-1:0] AMO_id_i,
  input  logic                      AMO_strobe_i,
  input  logic [XLEN-1:0]           AMO_addr_i,
  input  logic                      AMO_rw_i,
  input  logic [XLEN-1:0]           AMO_data_i,
  input  logic                      AMO_is_amo_i,
  input  logic [4:0]                AMO_amo_type_i,
  output logic                      AMO_data_ready_o,
  output logic [XLEN-1:0]           AMO_data_o,
  output logic                      M_strobe_o,
  output logic [XLEN-1:0]           M_addr_o,
  output logic                      M_rw_o,
  output logic [XLEN-1:0]           M_data_o,
  input  logic                      M_data_ready_i,
  input  logic [XLEN-1:0]           M_data_i,
  input  logic                      S_wr_strobe_i,
  input  logic [XLEN-1:0]           S_wr_addr_i
);

  amo_state_e state_q, state_d;

  logic                      in_lr, in_sc, in_store, sc_ok;
  logic                      accept, rd_done, wr_done, enter_mem;
  logic                      op_rmw_q, op_lr_q, op_sc_q;
  logic [CORE_NUMS_BITS-1:0] id_q;
  logic [XLEN-1:2]           waddr_q;
  logic [XLEN-1:0]           data_q, old_q, alu_new;
  logic [4:0]                type_q;
  logic                      unused_bits;

  assign in_lr    = AMO_is_amo_i && (AMO_amo_type_i == AMO_LR);
  assign in_sc    = AMO_is_amo_i && (AMO_amo_type_i == AMO_SC);
  assign in_store = !AMO_is_amo_i && AMO_rw_i;
  assign accept   = (state_q == S_IDLE) && AMO_strobe_i;
  assign rd_done  = (state_q == S_RD) && M_data_ready_i;
  assign wr_done  = (state_q == S_WR) && M_data_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (AMO_strobe_i) begin
          if (in_sc)          state_d = sc_ok ? S_WR : S_DONE;
          else if (in_store)  state_d = S_WR;
          else                state_d = S_RD;
        end
      end
      S_RD:    if (M_data_ready_i) state_d = op_rmw_q ? S_CALC : S_DONE;
      S_CALC:  state_d = S_WR;
      S_WR:    if (M_data_ready_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobe is registered, so it is raised on the edge that enters S_RD/S_WR.
  assign enter_mem        = (state_d != state_q) && ((state_d == S_RD) || (state_d == S_WR));
  assign AMO_data_ready_o = (state_q == S_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q       <= '0;
      waddr_q    <= '0;
      data_q     <= '0;
      type_q     <= '0;
      op_rmw_q   <= 1'b0;
      op_lr_q    <= 1'b0;
      op_sc_q    <= 1'b0;
      old_q      <= '0;
      AMO_data_o <= '0;
      M_strobe_o <= 1'b0;
      M_addr_o   <= '0;
      M_rw_o     <= 1'b0;
      M_data_o   <= '0;
    end else begin
      M_strobe_o <= enter_mem;
      if (accept) begin
        id_q     <= AMO_id_i;
        waddr_q  <= AMO_addr_i[XLEN-1:2];
        data_q   <= AMO_data_i;
        type_q   <= AMO_amo_type_i;
        op_rmw_q <= AMO_is_amo_i && !in_lr && !in_sc;
        op_lr_q  <= in_lr;
        op_sc_q  <= in_sc;
        M_addr_o <= {AMO_addr_i[XLEN-1:2], 2'b00};
        M_rw_o   <= (state_d == S_WR);
        M_data_o <= AMO_data_i;
        if (in_sc && !sc_ok) AMO_data_o <= {{(XLEN-1){1'b0}}, 1'b1};
      end
      if (state_q == S_CALC) begin
        M_rw_o   <= 1'b1;
        M_data_o <= alu_new;
      end
      if (rd_done) begin
        old_q      <= M_data_i;
        AMO_data_o <= M_data_i;
      end
      if (wr_done && op_sc_q) AMO_data_o <= '0;
    end
  end

  amo_alu #(.XLEN(XLEN)) u_alu (
    .old_val (old_q),
    .operand (data_q),
    .funct5  (type_q),
    .new_val (alu_new)
  );

`ifdef AMO_LRSC_EN
  resv_entry_t          resv_q [CORE_NUMS];
  logic [CORE_NUMS-1:0] sel_in, sel_q, resv_set, resv_clr;
  logic                 snoop_new;

  assign snoop_new = S_wr_strobe_i && (S_wr_addr_i[XLEN-1:2] == waddr_q);

  always_comb begin
    sc_ok    = 1'b0;
    sel_in   = '0;
    sel_q    = '0;
    resv_set = '0;
    resv_clr = '0;
    for (int unsigned k = 0; k < CORE_NUMS; k++) begin
      sel_in[k] = (CORE_NUMS_BITS'(k) == AMO_id_i);
      sel_q[k]  = (CORE_NUMS_BITS'(k) == id_q);
      if (sel_in[k] && resv_q[k].valid && (resv_q[k].addr == AMO_addr_i[XLEN-1:2]))
        sc_ok = 1'b1;
      resv_set[k] = rd_done && op_lr_q && sel_q[k];
      // A snoop matching the address being reserved this cycle must beat the set.
      resv_clr[k] = (accept && in_sc && sel_in[k])
                 || (wr_done && !sel_q[k] && (resv_q[k].addr == waddr_q))
                 || (S_wr_strobe_i && (resv_q[k].addr == S_wr_addr_i[XLEN-1:2]))
                 || (resv_set[k] && snoop_new);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < CORE_NUMS; k++) resv_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < CORE_NUMS; k++) begin
        if (resv_clr[k])      resv_q[k].valid <= 1'b0;
        else if (resv_set[k]) resv_q[k] <= '{valid: 1'b1, addr: waddr_q};
      end
    end
  end

  assign unused_bits = ^{AMO_addr_i[1:0], S_wr_addr_i[1:0]};
`else
  assign sc_ok       = 1'b0;
  assign unused_bits = ^{AMO_addr_i[1:0], S_wr_strobe_i, S_wr_addr_i, id_q, op_lr_q};
`endif

endmodule

// File: tb/tb_amo_executor.sv
// Self-checking bench for amo_executor: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
`ifndef CORE_NUMS
`define CORE_NUMS 2
`endif

module tb_amo_executor;

  localparam int CN  = `CORE_NUMS;
  localparam int IDW = (CN == 1) ? 1 : $clog2(CN);
`ifdef AMO_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif

  localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010,
                         F_SC = 5'b00011, F_XOR = 5'b00100, F_OR = 5'b01000,
                         F_AND = 5'b01100, F_MIN = 5'b10000, F_MAX = 5'b10100,
                         F_MINU = 5'b11000, F_MAXU = 5'b11100;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] AMO_id_i;
  logic           AMO_strobe_i;
  logic [31:0]    AMO_addr_i;
  logic           AMO_rw_i;
  logic [31:0]    AMO_data_i;
  logic           AMO_is_amo_i;
  logic [4:0]     AMO_amo_type_i;
  logic           AMO_data_ready_o;
  logic [31:0]    AMO_data_o;
  logic           M_strobe_o;
  logic [31:0]    M_addr_o;
  logic           M_rw_o;
  logic [31:0]    M_data_o;
  logic           M_data_ready_i;
  logic [31:0]    M_data_i;
  logic           S_wr_strobe_i;
  logic [31:0]    S_wr_addr_i;

  int vectors = 0;
  int miscompares = 0;
  int nstrobes = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  bit          rv_v [CN];
  logic [29:0] rv_a [CN];
  logic [4:0]  rmw_codes [12] = '{F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX,
                                  F_MINU, F_MAXU, 5'b00101, 5'b11111, 5'b01010};

  amo_executor dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .AMO_id_i         (AMO_id_i),
    .AMO_strobe_i     (AMO_strobe_i),
    .AMO_addr_i       (AMO_addr_i),
    .AMO_rw_i         (AMO_rw_i),
    .AMO_data_i       (AMO_data_i),
    .AMO_is_amo_i     (AMO_is_amo_i),
    .AMO_amo_type_i   (AMO_amo_type_i),
    .AMO_data_ready_o (AMO_data_ready_o),
    .AMO_data_o       (AMO_data_o),
    .M_strobe_o       (M_strobe_o),
    .M_addr_o         (M_addr_o),
    .M_rw_o           (M_rw_o),
    .M_data_o         (M_data_o),
    .M_data_ready_i   (M_data_ready_i),
    .M_data_i         (M_data_i),
    .S_wr_strobe_i    (S_wr_strobe_i),
    .S_wr_addr_i      (S_wr_addr_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: completes each request one cycle after its strobe.
  initial begin : responder
    bit          pend;
    bit          p_rw;
    int          p_w;
    logic [31:0] p_d;
    pend = 0; p_rw = 0; p_w = 0; p_d = '0;
    M_data_ready_i = 1'b0;
    M_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      M_data_ready_i = 1'b0;
      if (rst_i) begin
        pend = 0;
      end else begin
        if (pend) begin
          M_data_ready_i = 1'b1;
          if (p_rw) mem[p_w] = p_d;
          else      M_data_i = mem[p_w];
          pend = 0;
        end
        if (M_strobe_o) begin
          pend = 1; p_rw = M_rw_o; p_w = int'(M_addr_o[11:2]); p_d = M_data_o;
          nstrobes++;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f)
      F_SWAP: return b;
      F_XOR:  return a ^ b;
      F_OR:   return a | b;
      F_AND:  return a & b;
      F_MIN:  return (sa < sb) ? a : b;
      F_MAX:  return (sa > sb) ? a : b;
      F_MINU: return (a < b) ? a : b;
      F_MAXU: return (a > b) ? a : b;
      default: return a + b;
    endcase
  endfunction

  task automatic snoop(input logic [31:0] a);
    S_wr_strobe_i = 1'b1;
    S_wr_addr_i = a;
    tick();
    S_wr_strobe_i = 1'b0;
    for (int c = 0; c < CN; c++) if (rv_a[c] == a[31:2]) rv_v[c] = 0;
  endtask

  task automatic do_op(input int id, input logic [31:0] addr, input bit amo,
                       input logic [4:0] ft, input bit rw, input logic [31:0] d,
                       input int snoop_cyc = 0, input logic [31:0] snoop_addr = '0,
                       input int extra_cyc = 0);
    int          w, cyc, exp_lat, exp_strb, strb0;
    logic [31:0] old, exp_res;
    logic [29:0] wa;
    bit          chk_res, wrote, ok;
    w = int'(addr[11:2]);
    wa = addr[31:2];
    old = ref_mem[w];
    chk_res = 1; wrote = 0; exp_res = '0;
    if (amo && ft == F_LR) begin
      exp_lat = 3; exp_strb = 1; exp_res = old;
      if (LRSC) begin rv_v[id] = 1; rv_a[id] = wa; end
    end else if (amo && ft == F_SC) begin
      ok = LRSC && rv_v[id] && (rv_a[id] == wa);
      rv_v[id] = 0;
      if (ok) begin
        exp_lat = 3; exp_strb = 1; exp_res = 0; ref_mem[w] = d; wrote = 1;
      end else begin
        exp_lat = 1; exp_strb = 0; exp_res = 1;
      end
    end else if (amo) begin
      exp_lat = 6; exp_strb = 2; exp_res = old; ref_mem[w] = ref_alu(ft, old, d); wrote = 1;
    end else if (rw) begin
      exp_lat = 3; exp_strb = 1; ref_mem[w] = d; wrote = 1; chk_res = 0;
    end else begin
      exp_lat = 3; exp_strb = 1; exp_res = old;
    end
    if (wrote)
      for (int c = 0; c < CN; c++) if (c != id && rv_a[c] == wa) rv_v[c] = 0;
    if (snoop_cyc > 0)
      for (int c = 0; c < CN; c++) if (rv_a[c] == snoop_addr[31:2]) rv_v[c] = 0;

    strb0 = nstrobes;
    AMO_id_i = IDW'(id); AMO_addr_i = addr; AMO_is_amo_i = amo; AMO_amo_type_i = ft;
    AMO_rw_i = rw; AMO_data_i = d; AMO_strobe_i = 1'b1;
    tick();
    AMO_strobe_i = 1'b0;
    cyc = 1;
    while (AMO_data_ready_o !== 1'b1 && cyc < 20) begin
      S_wr_strobe_i = (cyc == snoop_cyc);
      S_wr_addr_i = snoop_addr;
      if (cyc == extra_cyc) begin
        AMO_strobe_i = 1'b1; AMO_is_amo_i = 1'b0; AMO_rw_i = 1'b1;
        AMO_addr_i = 32'h3F0; AMO_data_i = 32'hDEADBEEF;
      end else begin
        AMO_strobe_i = 1'b0;
      end
      tick();
      cyc++;
    end
    S_wr_strobe_i = 1'b0;
    AMO_strobe_i = 1'b0;
    check("latency", cyc, exp_lat);
    if (chk_res) check("result", AMO_data_o, exp_res);
    check("mem_word", mem[w], ref_mem[w]);
    check("mem_strobes", nstrobes - strb0, exp_strb);
    if (exp_strb > 0) check("mem_addr", M_addr_o, {addr[31:2], 2'b00});
    tick();
    check("ready_pulse", AMO_data_ready_o, 0);
  endtask

  initial begin : stim
    rst_i = 1'b1;
    AMO_id_i = '0; AMO_strobe_i = 0; AMO_addr_i = '0; AMO_rw_i = 0; AMO_data_i = '0;
    AMO_is_amo_i = 0; AMO_amo_type_i = '0; S_wr_strobe_i = 0; S_wr_addr_i = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int c = 0; c < CN; c++) begin rv_v[c] = 0; rv_a[c] = '0; end
    tick(); tick();
    check("rst_ready", AMO_data_ready_o, 0);
    check("rst_data", AMO_data_o, 0);
    check("rst_mstrobe", M_strobe_o, 0);
    check("rst_maddr", M_addr_o, 0);
    check("rst_mrw", M_rw_o, 0);
    check("rst_mdata", M_data_o, 0);
    rst_i = 1'b0;
    tick();

    // AMOADD overflow wrap
    mem[64] = 32'h7FFFFFFF; ref_mem[64] = 32'h7FFFFFFF;
    do_op(0, 32'h100, 1, F_ADD, 0, 32'h1);
    check("amoadd_wrap", mem[64], 32'h80000000);

    // signed vs unsigned minimum
    mem[65] = 32'hFFFFFFFF; ref_mem[65] = 32'hFFFFFFFF;
    do_op(0, 32'h104, 1, F_MIN, 0, 32'd5);
    check("amomin_signed", mem[65], 32'hFFFFFFFF);
    mem[65] = 32'hFFFFFFFF; ref_mem[65] = 32'hFFFFFFFF;
    do_op(1 % CN, 32'h104, 1, F_MINU, 0, 32'd5);
    check("amominu_unsigned", mem[65], 32'd5);

    // LR then SC succeeds once, repeated SC fails
    do_op(0, 32'h200, 1, F_LR, 0, 0);
    do_op(0, 32'h200, 1, F_SC, 0, 32'hA5);
`ifdef AMO_LRSC_EN
    check("sc_store", mem[128], 32'hA5);
`endif
    do_op(0, 32'h200, 1, F_SC, 0, 32'h5A);

    // another core's write breaks the reservation
    do_op(0, 32'h200, 1, F_LR, 0, 0);
    do_op(1 % CN, 32'h200, 1, F_SWAP, 0, 32'h1234);
    do_op(0, 32'h200, 1, F_SC, 0, 32'h77);

    // snoop in the read-completion cycle wins over the LR set
    do_op(0, 32'h300, 1, F_LR, 0, 0, 2, 32'h300);
    do_op(0, 32'h300, 1, F_SC, 0, 32'h99);

    // strobe while busy must be ignored
    do_op(0, 32'h108, 1, F_XOR, 0, 32'h0F0F0F0F, 0, '0, 2);
    check("busy_strobe_ignored", mem[252], ref_mem[252]);

    // reset during S_WR drops the write and the reservations
    do_op(0, 32'h120, 1, F_LR, 0, 0);
    AMO_id_i = '0; AMO_addr_i = 32'h124; AMO_is_amo_i = 1; AMO_amo_type_i = F_ADD;
    AMO_rw_i = 0; AMO_data_i = 32'h11; AMO_strobe_i = 1;
    tick();
    AMO_strobe_i = 0;
    tick(); tick(); tick();
    check("wr_phase_strobe", M_strobe_o, 1);
    check("wr_phase_rw", M_rw_o, 1);
    rst_i = 1'b1;
    tick();
    check("mid_rst_ready", AMO_data_ready_o, 0);
    check("mid_rst_mstrobe", M_strobe_o, 0);
    check("mid_rst_data", AMO_data_o, 0);
    check("mid_rst_mrw", M_rw_o, 0);
    rst_i = 1'b0;
    for (int c = 0; c < CN; c++) rv_v[c] = 0;
    tick();
    check("mid_rst_mem", mem[73], ref_mem[73]);
    do_op(0, 32'h124, 0, F_ADD, 0, 0);
    do_op(0, 32'h120, 1, F_SC, 0, 32'h55);

    // randomized traffic over a small address window so reservations collide
    for (int i = 0; i < 150; i++) begin
      int          id, r;
      logic [31:0] a, d;
      id = $urandom_range(CN - 1, 0);
      a = 32'h100 + 32'($urandom_range(31, 0));
      d = $urandom;
      r = $urandom_range(9, 0);
      case (r)
        0, 1:    do_op(id, a, 1, F_LR, 0, 0);
        2, 3:    do_op(id, a, 1, F_SC, 0, d);
        4, 5, 6: do_op(id, a, 1, rmw_codes[$urandom_range(11, 0)], 0, d);
        7:       do_op(id, a, 0, F_ADD, 0, d);
        8:       do_op(id, a, 0, F_ADD, 1, d);
        default: snoop(a);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
